// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: opcode constants, queue depth default and queue entry layout
package inst_fetch_unit_pkg;
  localparam int IQ_BIT_DEF = 2;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } iq_entry_t;
endpackage

// File: rtl/inst_fetch_unit_inst_queue.sv
// inst_queue: circular FIFO with push/pop/flush, occupancy count and head-entry output
module inst_queue #(
  parameter int IQ_BIT = 2,
  parameter int W = 97
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      dout,
  output logic [IQ_BIT:0]   count
);
  logic [W-1:0] mem_q [1<<IQ_BIT];
  logic [IQ_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [IQ_BIT:0] count_q, count_d;
  always_comb begin
    head_d = flush ? '0 : head_q + IQ_BIT'(pop);
    tail_d = flush ? '0 : tail_q + IQ_BIT'(push);
    count_d = flush ? '0 : count_q + (IQ_BIT+1)'(push) - (IQ_BIT+1)'(pop);
    dout = mem_q[head_q];
    count = count_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (push && !flush && !rst_in) mem_q[tail_q] <= din;
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC owner with static prediction feeding a small instruction queue
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int IQ_BIT = IQ_BIT_DEF,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] pc,
  output logic        inst_req,
  input  logic        inst_ready,
  input  logic [31:0] inst_res,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_pc,
  input  logic        out_ready
);
  logic [31:0] pc_q, pc_d, imm_j, imm_b, pred_pc;
  logic [6:0] opc;
  logic pred_taken, full, fetch, pop, flush;
  logic [IQ_BIT:0] count;
  iq_entry_t head, entry;
  always_comb begin
    opc = inst_res[6:0];
    imm_j = {{12{inst_res[31]}}, inst_res[19:12], inst_res[20], inst_res[30:21], 1'b0};
    imm_b = {{20{inst_res[31]}}, inst_res[7], inst_res[30:25], inst_res[11:8], 1'b0};
    pred_taken = opc == OPC_JAL || (opc == OPC_BRANCH && inst_res[31]);
    pred_pc = opc == OPC_JALR ? pc_q + 32'd4 :
              opc == OPC_JAL ? pc_q + imm_j :
              pred_taken ? pc_q + imm_b : pc_q + 32'd4;
    entry = '{inst: inst_res, pc: pc_q, pred_taken: pred_taken, pred_pc: pred_pc};
    full = count == (IQ_BIT+1)'(1 << IQ_BIT);
    out_valid = count != '0;
    inst_req = !rst_in && rdy_in && !clear && !full;
    fetch = inst_req && inst_ready;
    flush = rdy_in && clear;
    pop = rdy_in && !clear && out_valid && out_ready;
    pc_d = flush ? clear_pc : fetch ? pred_pc : pc_q;
    pc = pc_q;
    out_inst = head.inst;
    out_pc = head.pc;
    out_pred_taken = head.pred_taken;
    out_pred_pc = head.pred_pc;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  inst_queue #(.IQ_BIT(IQ_BIT), .W($bits(iq_entry_t))) u_iq (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push(fetch),
    .pop(pop),
    .flush(flush),
    .din(entry),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed vector table plus randomized run against a queue-based model
module tb_inst_fetch_unit;
  logic clk_in = 0, rst_in, rdy_in, inst_req, inst_ready, clear, out_valid, out_pred_taken, out_ready;
  logic [31:0] pc, inst_res, clear_pc, out_inst, out_pc, out_pred_pc;
  int checks = 0, errors = 0;
  always #5 clk_in = ~clk_in;
  inst_fetch_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc(pc), .inst_req(inst_req),
    .inst_ready(inst_ready), .inst_res(inst_res), .clear(clear), .clear_pc(clear_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_pred_taken(out_pred_taken),
    .out_pred_pc(out_pred_pc), .out_ready(out_ready)
  );
  typedef struct {
    logic rst, rdy, ir;
    logic [31:0] res;
    logic clr;
    logic [31:0] cpc;
    logic ordy, req;
    logic [31:0] pc;
    logic valid;
    logic [31:0] opc;
    logic taken;
    logic [31:0] ppc;
  } vec_t;
  typedef struct {
    logic [31:0] inst, pc;
    logic taken;
    logic [31:0] ppc;
  } ent_t;
  vec_t tbl[$];
  ent_t mq[$];
  logic [31:0] mpc;
  localparam logic [31:0] NOP = 32'h00000013;
  function automatic vec_t mk(logic rst, logic rdy, logic ir, logic [31:0] res, logic clr, logic [31:0] cpc,
                              logic ordy, logic req, logic [31:0] p, logic valid, logic [31:0] opc,
                              logic taken, logic [31:0] ppc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ir = ir; v.res = res; v.clr = clr; v.cpc = cpc; v.ordy = ordy;
    v.req = req; v.pc = p; v.valid = valid; v.opc = opc; v.taken = taken; v.ppc = ppc;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic drive(logic rst, logic rdy, logic ir, logic [31:0] res, logic clr, logic [31:0] cpc, logic ordy);
    rst_in = rst; rdy_in = rdy; inst_ready = ir; inst_res = res; clear = clr; clear_pc = cpc; out_ready = ordy;
  endtask
  function automatic void predict(logic [31:0] inst, logic [31:0] p, output logic t, output logic [31:0] npc);
    int off;
    t = 0;
    off = 4;
    if (inst[6:0] == 7'h6F) begin
      t = 1;
      off = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    end else if (inst[6:0] == 7'h63 && inst[31]) begin
      t = 1;
      off = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    end
    npc = p + 32'(off);
  endfunction
  task automatic mstep(logic rst, logic rdy, logic ir, logic [31:0] res, logic clr, logic [31:0] cpc, logic ordy);
    logic req;
    ent_t e;
    drive(rst, rdy, ir, res, clr, cpc, ordy);
    req = !rst && rdy && !clr && mq.size() < 4;
    @(negedge clk_in);
    chk("rnd_req", 32'(inst_req), 32'(req));
    chk("rnd_pc", pc, mpc);
    chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rnd_out_inst", out_inst, mq[0].inst);
      chk("rnd_out_pc", out_pc, mq[0].pc);
      chk("rnd_out_taken", 32'(out_pred_taken), 32'(mq[0].taken));
      chk("rnd_out_pred_pc", out_pred_pc, mq[0].ppc);
    end
    if (rst) begin
      mq.delete();
      mpc = 0;
    end else if (rdy && clr) begin
      mq.delete();
      mpc = cpc;
    end else if (rdy) begin
      if (ordy && mq.size() != 0) void'(mq.pop_front());
      if (req && ir) begin
        e.inst = res;
        e.pc = mpc;
        predict(res, mpc, e.taken, e.ppc);
        mq.push_back(e);
        mpc = e.ppc;
      end
    end
    @(posedge clk_in);
    #1;
  endtask
  initial begin
    drive(1, 1, 0, NOP, 0, 0, 0);
    repeat (2) @(posedge clk_in);
    #1;
    tbl.push_back(mk(0,1,1,NOP,0,0,0, 1,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,1,NOP,0,0,0, 1,32'h4,1,32'h0,0,32'h4));
    tbl.push_back(mk(0,1,1,NOP,0,0,0, 1,32'h8,1,32'h0,0,32'h4));
    tbl.push_back(mk(0,1,1,NOP,0,0,0, 1,32'hC,1,32'h0,0,32'h4));
    tbl.push_back(mk(0,1,1,NOP,0,0,0, 0,32'h10,1,32'h0,0,32'h4));
    tbl.push_back(mk(0,1,1,NOP,0,0,1, 0,32'h10,1,32'h0,0,32'h4));
    tbl.push_back(mk(0,1,1,NOP,0,0,1, 1,32'h10,1,32'h4,0,32'h8));
    tbl.push_back(mk(0,1,1,NOP,0,0,1, 1,32'h14,1,32'h8,0,32'hC));
    tbl.push_back(mk(0,1,1,NOP,0,0,1, 1,32'h18,1,32'hC,0,32'h10));
    tbl.push_back(mk(0,1,1,NOP,1,32'h400,1, 0,32'h1C,1,32'h10,0,32'h14));
    tbl.push_back(mk(0,1,0,NOP,0,0,0, 1,32'h400,0,0,0,0));
    tbl.push_back(mk(0,1,0,NOP,1,32'h100,0, 0,32'h400,0,0,0,0));
    tbl.push_back(mk(0,1,1,32'hFF9FF06F,0,0,0, 1,32'h100,0,0,0,0));
    tbl.push_back(mk(0,1,0,NOP,0,0,0, 1,32'hF8,1,32'h100,1,32'hF8));
    tbl.push_back(mk(0,1,0,NOP,1,32'h200,0, 0,32'hF8,1,32'h100,1,32'hF8));
    tbl.push_back(mk(0,1,1,32'h00000863,0,0,0, 1,32'h200,0,0,0,0));
    tbl.push_back(mk(0,1,0,NOP,0,0,0, 1,32'h204,1,32'h200,0,32'h204));
    tbl.push_back(mk(0,1,0,NOP,1,32'h200,0, 0,32'h204,1,32'h200,0,32'h204));
    tbl.push_back(mk(0,1,1,32'hFE0008E3,0,0,0, 1,32'h200,0,0,0,0));
    tbl.push_back(mk(0,1,0,NOP,0,0,0, 1,32'h1F0,1,32'h200,1,32'h1F0));
    tbl.push_back(mk(0,0,1,NOP,0,0,1, 0,32'h1F0,1,32'h200,1,32'h1F0));
    tbl.push_back(mk(0,0,1,NOP,0,0,1, 0,32'h1F0,1,32'h200,1,32'h1F0));
    tbl.push_back(mk(0,0,1,NOP,0,0,1, 0,32'h1F0,1,32'h200,1,32'h1F0));
    tbl.push_back(mk(0,1,1,NOP,0,0,1, 1,32'h1F0,1,32'h200,1,32'h1F0));
    tbl.push_back(mk(0,1,0,NOP,0,0,0, 1,32'h1F4,1,32'h1F0,0,32'h1F4));
    tbl.push_back(mk(1,0,1,NOP,1,32'h800,1, 0,32'h1F4,1,32'h1F0,0,32'h1F4));
    tbl.push_back(mk(0,1,0,NOP,0,0,0, 1,32'h0,0,0,0,0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].ir, tbl[i].res, tbl[i].clr, tbl[i].cpc, tbl[i].ordy);
      @(negedge clk_in);
      chk($sformatf("v%0d_req", i), 32'(inst_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, tbl[i].opc);
        chk($sformatf("v%0d_taken", i), 32'(out_pred_taken), 32'(tbl[i].taken));
        chk($sformatf("v%0d_pred_pc", i), out_pred_pc, tbl[i].ppc);
      end
      @(posedge clk_in);
      #1;
    end
    mq.delete();
    mpc = 0;
    mstep(1, 1, 0, NOP, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      logic [6:0] op;
      r = $urandom;
      case ($urandom_range(0, 3))
        0: op = 7'h6F;
        1: op = 7'h63;
        2: op = 7'h67;
        default: op = 7'h13;
      endcase
      r[6:0] = op;
      mstep($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, r,
            $urandom_range(0, 99) < 5, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Front-end stage directly upstream of the memory unit's instruction port. It owns the architectural fetch PC and drives pc/inst_req toward the memory unit. Each instruction returned on inst_ready/inst_res is pushed, with its PC and a static prediction, into a small instruction queue. The decoder drains that queue through a valid/ready handshake. A clear/redirect from the ROB flushes the queue and reloads the PC.

Parameters:
IQ_BIT, 2, log2 of instruction-queue depth (depth = 1<<IQ_BIT = 4 entries)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; all state holds while low
pc  output  32  fetch address to memory unit (the fetch PC register)
inst_req  output  1  fetch request to memory unit
inst_ready  input  1  memory unit: inst_res valid for current pc (same-cycle cache hit)
inst_res  input  32  instruction word at pc
clear  input  1  flush/redirect from ROB (also seen by memory unit)
clear_pc  input  32  redirect target, valid with clear
out_valid  output  1  queue head valid
out_inst  output  32  head instruction
out_pc  output  32  head PC
out_pred_taken  output  1  static prediction for head
out_pred_pc  output  32  predicted next PC for head
out_ready  input  1  decoder consumes head this cycle

Behaviour:
- Clock and reset: single clock clk_in. Reset is synchronous, active-high on rst_in.
- Reset values: pc=RESET_PC, queue empty (head=tail=count=0), out_valid=0.
- inst_req is combinational: !rst_in && rdy_in && !clear && !full, where full = count==(1<<IQ_BIT).
- Fetch accept: a cycle with inst_req && inst_ready is a fetch. In that cycle:
  - push {inst_res, pc, pred_taken, pred_pc} at tail;
  - pc <= pred_pc.
- Fetch latency: one cycle from hit to out_valid when the queue was empty.
- Static predictor, combinational on inst_res[6:0]:
  - JAL (1101111): taken, target = pc + sext(J-imm).
  - BRANCH (1100011): taken iff B-imm sign bit (inst[31]) = 1 (backward), target = pc + sext(B-imm); otherwise pc+4.
  - JALR and all other opcodes: not taken, pc+4.
  - All adds are 32-bit, wrap modulo 2^32.
- Dequeue: out_valid = (count != 0). out_* is driven combinationally from the head entry. A pop happens when out_valid && out_ready.
- Simultaneous push and pop: count is unchanged, and head and tail both advance. A push is allowed when full only if... no: inst_req is deasserted when full, so push-while-full never happens, even with a same-cycle pop. That costs one bubble and is accepted.
- Pointer wrap: head and tail are IQ_BIT wide and wrap naturally; count is IQ_BIT+1 bits.
- clear (priority over fetch and pop):
  - head=tail=count=0, pc <= clear_pc;
  - nothing pushed that cycle, even if inst_ready is high;
  - out_valid falls the next cycle.
  - A pop in the same cycle is ignored; the decoder also sees clear.
- rdy_in low: no state changes, inst_req=0. out_* stays stable, since it is combinational from held state.
- Reset mid-operation: rst_in overrides clear and rdy_in; queue contents are discarded.
- The memory unit may abort a miss when pc changes. The fetch unit needs no handshake for this: it holds pc until a hit, and changes pc only on a fetch or on clear.

Decomposition:
- Opcode constants (OPC_JAL, OPC_BRANCH, OPC_JALR) and IQ_BIT default go in the shared const.v.
- Sub-module inst_queue: circular FIFO with push/pop/flush, count, head-entry outputs, parameterized by IQ_BIT and entry width (97 bits: inst, pc, pred_taken, pred_pc).
- Prediction and immediate extraction stay inline in inst_fetch_unit.

Test Plan:
- Reset, then inst_ready=1 with inst_res=NOP (0x00000013) every cycle, out_ready=0 -> pc steps 0,4,8,12; after 4 pushes inst_req=0, count=4, pc holds at 16.
- Queue at depth 4, out_ready=1 and inst_ready=1 continuously -> throughput: no push in the cycle full is seen, steady state sustains one pop per cycle with a one-bubble recovery; out_pc sequence strictly +4.
- At pc=0x100, inst_res=JAL x0,-8 (0xFF9FF06F) -> out_pred_taken=1, out_pred_pc=0x0F8, next pc=0x0F8.
- At pc=0x200: inst_res=BEQ +16 (0x00000863) -> pred_taken=0, next pc=0x204; BEQ -16 (0xFE0008E3) -> pred_taken=1, next pc=0x1F0.
- Queue holding 3 entries, assert clear with clear_pc=0x400 and inst_ready=1 in the same cycle -> next cycle out_valid=0, count=0, pc=0x400; inst_res from the clear cycle is not enqueued.
- rdy_in=0 for 3 cycles with inst_ready=1 and out_ready=1 -> inst_req=0, pc/count/head unchanged; resumes exactly where it stopped when rdy_in=1.
